// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Op encoding, FSM states and byte-lane masks.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_store(op_t o);
        return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
    endfunction

    function automatic logic addr_ok(op_t o, logic [1:0] a);
        logic ok;
        ok = 1'b1;
        case (o)
            OP_LW, OP_SW:          ok = (a == 2'b00);
            OP_LH, OP_LHU, OP_SH:  ok = ~a[0];
            default:               ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the byte/halfword lane
// and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    op_t         w_op;

    always_comb begin
        w_op    = op_t'(i_op);
        w_byte  = 8'h00;
        w_half  = i_addr_lo[1] ? i_mem_rdata[31:16]
                               : i_mem_rdata[15:0];
        o_rdata = i_mem_rdata;
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        case (w_op)
            OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_rdata = {24'h0, w_byte};
            OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_rdata = {16'h0, w_half};
            default: o_rdata = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one access at a time onto a
// variable-latency memory bus, with misalign and timeout reporting.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [9:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_timeout;

    op_t         w_op;
    logic        w_accept;
    logic        w_mis_hit;
    logic        w_ack_hit;
    logic        w_tmo_hit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_op = op_t'(op);

    lsu_load_align u_align (
        .i_op        (r_op),
        .i_addr_lo   (r_addr_lo),
        .i_mem_rdata (mem_rdata),
        .o_rdata     (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mis_hit   = 1'b0;
        w_ack_hit   = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (start && addr_ok(w_op, addr[1:0])) begin
                    w_state_nxt = S_REQ;
                    w_accept    = 1'b1;
                end else if (start) begin
                    w_state_nxt = S_ERR;
                    w_mis_hit   = 1'b1;
                end
            end
            // An ack on the final counted cycle takes priority.
            S_REQ: begin
                if (mem_ack) begin
                    w_state_nxt = S_DONE;
                    w_ack_hit   = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_ERR;
                    w_tmo_hit   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_be    = BE_WORD;
        w_wdata = 32'h0;
        case (w_op)
            OP_SB: begin
                w_be    = BE_BYTE << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            OP_SH: begin
                w_be    = BE_HALF << addr[1:0];
                w_wdata = {2{wdata[15:0]}};
            end
            OP_SW:   w_wdata = wdata;
            default: w_be    = BE_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_cnt      <= 10'd0;
            r_we       <= 1'b0;
            r_mem_addr <= 32'h0;
            r_be       <= 4'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= op;
                r_addr_lo  <= addr[1:0];
                r_we       <= is_store(w_op);
                r_mem_addr <= {addr[31:2], 2'b00};
                r_be       <= w_be;
                r_wdata    <= w_wdata;
            end
            if (r_state == S_REQ && !mem_ack) r_cnt <= r_cnt + 10'd1;
            else                              r_cnt <= 10'd0;
            if (w_ack_hit)
                r_rdata <= r_we ? 32'h0 : w_load_data;
            else if (w_mis_hit || w_tmo_hit)
                r_rdata <= 32'h0;
            r_misalign <= w_mis_hit;
            r_timeout  <= w_tmo_hit;
        end
    end

    assign busy      = (r_state == S_REQ);
    assign mem_req   = (r_state == S_REQ);
    assign done      = (r_state == S_DONE) || (r_state == S_ERR);
    assign misalign  = r_misalign;
    assign timeout   = r_timeout;
    assign rdata     = r_rdata;
    assign mem_we    = r_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

endmodule
